// File: rtl/dma_ctrl.sv
// dma_ctrl: memory-to-memory DMA engine and bus arbiter for the 6502 system bus.
// The CPU programs SRC/DST/LEN/CTRL through an 8-byte window at F700-F7FF. A start
// takes the bus by holding CPU RDY low, and then copies one byte every two cycles
// (RD, WR). After BURST bytes the bus is handed back to the CPU for one cycle.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cs, we, addr    CPU register window select / write enable / register index
//   din, dout       CPU write data / registered read data
//   mem_di          system read data, valid one cycle after the address
//   dma_ab, dma_do  DMA address and write data onto the system bus
//   dma_we          DMA write strobe (only in WR)
//   bus_own         top level selects DMA bus signals when 1
//   cpu_rdy         CPU RDY, always the complement of bus_own
//   irq             level interrupt, done & irq_en
module dma_ctrl #(
  parameter int BURST = 16,
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  mem_di,
  output logic [15:0] dma_ab,
  output logic [7:0]  dma_do,
  output logic        dma_we,
  output logic        bus_own,
  output logic        cpu_rdy,
  output logic        irq
);

  localparam int BCW = (BURST > 0) ? $clog2(BURST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_RD    = 3'd2,
    S_WR    = 3'd3,
    S_YIELD = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [BCW-1:0]   burst_q, burst_d;
  logic             irq_en_q, irq_en_d;
  logic             src_fixed_q, src_fixed_d;
  logic             dst_fixed_q, dst_fixed_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       dout_q, dout_d;
  logic [15:0]      ab_q, ab_d;
  logic             we_q, we_d;
  logic             own_q, own_d;
  logic             rdy_q, rdy_d;

  logic             cpu_wr;
  logic [7:0]       rdata;
  logic [15:0]      len_rd;
  logic [15:0]      len_wr;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    burst_d     = burst_q;
    irq_en_d    = irq_en_q;
    src_fixed_d = src_fixed_q;
    dst_fixed_d = dst_fixed_q;
    busy_d      = busy_q;
    done_d      = done_q;
    dout_d      = dout_q;
    len_rd      = 16'(len_q);
    len_wr      = len_rd;
    rdata       = '0;

    // Only cycles where the CPU really drives the bus can write the window.
    cpu_wr = cs & we & rdy_q;

    case (addr)
      3'd0:    rdata = src_q[7:0];
      3'd1:    rdata = src_q[15:8];
      3'd2:    rdata = dst_q[7:0];
      3'd3:    rdata = dst_q[15:8];
      3'd4:    rdata = len_rd[7:0];
      3'd5:    rdata = len_rd[15:8];
      3'd6:    rdata = {4'b0, dst_fixed_q, src_fixed_q, irq_en_q, 1'b0};
      default: rdata = {6'b0, done_q, busy_q};
    endcase

    if (cs && !we) begin
      dout_d = rdata;
    end

    // While busy only irq_en and the done-clear are writable.
    if (cpu_wr) begin
      case (addr)
        3'd0: if (!busy_q) src_d[7:0]  = din;
        3'd1: if (!busy_q) src_d[15:8] = din;
        3'd2: if (!busy_q) dst_d[7:0]  = din;
        3'd3: if (!busy_q) dst_d[15:8] = din;
        3'd4: if (!busy_q) begin
          len_wr[7:0] = din;
          len_d       = LEN_W'(len_wr);
        end
        3'd5: if (!busy_q) begin
          len_wr[15:8] = din;
          len_d        = LEN_W'(len_wr);
        end
        3'd6: begin
          irq_en_d = din[1];
          if (!busy_q) begin
            src_fixed_d = din[2];
            dst_fixed_d = din[3];
          end
        end
        default: if (din[1]) done_d = 1'b0;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_wr && addr == 3'd6 && din[0] && !busy_q) begin
          burst_d = '0;
          if (len_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GRANT;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      S_GRANT: state_d = S_RD;
      S_RD:    state_d = S_WR;
      S_WR: begin
        src_d   = src_fixed_q ? src_q : src_q + 16'd1;
        dst_d   = dst_fixed_q ? dst_q : dst_q + 16'd1;
        len_d   = len_q - LEN_W'(1);
        burst_d = burst_q + BCW'(1);
        if (len_d == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (BURST != 0 && burst_d == BCW'(BURST)) begin
          state_d = S_YIELD;
        end else begin
          state_d = S_RD;
        end
      end
      S_YIELD: begin
        burst_d = '0;
        state_d = S_GRANT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with it.
    own_d = (state_d == S_GRANT) || (state_d == S_RD) || (state_d == S_WR);
    rdy_d = ~own_d;
    we_d  = (state_d == S_WR);
    ab_d  = ab_q;
    if (state_d == S_RD) begin
      ab_d = src_d;
    end else if (state_d == S_WR) begin
      ab_d = dst_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      irq_en_q    <= 1'b0;
      src_fixed_q <= 1'b0;
      dst_fixed_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= '0;
      ab_q        <= '0;
      we_q        <= 1'b0;
      own_q       <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      irq_en_q    <= irq_en_d;
      src_fixed_q <= src_fixed_d;
      dst_fixed_q <= dst_fixed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      ab_q        <= ab_d;
      we_q        <= we_d;
      own_q       <= own_d;
      rdy_q       <= rdy_d;
    end
  end

  assign dout    = dout_q;
  assign dma_ab  = ab_q;
  assign dma_we  = we_q;
  assign bus_own = own_q;
  assign cpu_rdy = rdy_q;
  assign irq     = done_q & irq_en_q;
  // Read data only arrives during WR, so the write data is passed straight through.
  assign dma_do  = we_q ? mem_di : '0;

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: self-checking bench for dma_ctrl. A 64 KiB memory with synchronous
// read sits on the DMA bus; the bench plays the CPU on the register window.
module tb_dma_ctrl;

  localparam int TB_BURST = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [7:0]  mem_di;
  logic [15:0] dma_ab;
  logic [7:0]  dma_do;
  logic        dma_we;
  logic        bus_own;
  logic        cpu_rdy;
  logic        irq;

  int total = 0;
  int bad   = 0;

  dma_ctrl #(.BURST(TB_BURST), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .mem_di(mem_di), .dma_ab(dma_ab), .dma_do(dma_do), .dma_we(dma_we),
    .bus_own(bus_own), .cpu_rdy(cpu_rdy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Unwritten locations return a fixed address pattern (acts as ROM contents).
  logic [7:0] ram [0:65535];
  bit         written [0:65535];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] cur_mem(input logic [15:0] a);
    return written[a] ? ram[a] : pat(a);
  endfunction

  always @(posedge clk) begin
    mem_di <= cur_mem(dma_ab);
    if (dma_we) begin
      ram[dma_ab]     <= dma_do;
      written[dma_ab] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    d = dout;
    cs = 1'b0;
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [7:0]  ctrl;
    int          inj_k;
    logic [2:0]  inj_a;
    logic [7:0]  inj_d;
    logic [15:0] exp_src;
    logic [15:0] exp_dst;
    int          exp_low;
    logic        exp_irq;
  } vec_t;

  typedef enum {PH_GRANT, PH_RD, PH_WR, PH_YIELD, PH_DONE} ph_e;

  // Programs and runs one transfer, checking every bus cycle against a schedule
  // derived from the transfer rules, then the final register state.
  task automatic run_xfer(input vec_t v, input string tag);
    ph_e         sched[$];
    logic [15:0] sa[$];
    logic [15:0] da[$];
    logic [7:0]  dd[$];
    int          low = 0;
    int          bi  = 0;
    logic [7:0]  lo, hi;
    bit          exp_free;
    for (int i = 0; i < int'(v.len); i++) begin
      logic [15:0] s_i;
      logic [15:0] d_i;
      bit          y;
      y   = (i > 0) && (TB_BURST != 0) && (i % TB_BURST == 0);
      s_i = v.ctrl[2] ? v.src : v.src + 16'(i);
      d_i = v.ctrl[3] ? v.dst : v.dst + 16'(i);
      if (y) sched.push_back(PH_YIELD);
      if (i == 0 || y) sched.push_back(PH_GRANT);
      sched.push_back(PH_RD);
      sched.push_back(PH_WR);
      sa.push_back(s_i);
      da.push_back(d_i);
      dd.push_back(cur_mem(s_i));
    end
    sched.push_back(PH_DONE);

    cpu_write(3'd0, v.src[7:0]);
    cpu_write(3'd1, v.src[15:8]);
    cpu_write(3'd2, v.dst[7:0]);
    cpu_write(3'd3, v.dst[15:8]);
    cpu_write(3'd4, v.len[7:0]);
    cpu_write(3'd5, v.len[15:8]);
    cpu_write(3'd6, v.ctrl);

    for (int k = 0; k < sched.size(); k++) begin
      case (sched[k])
        PH_RD: begin
          check($sformatf("%s rd_ab k=%0d", tag, k), dma_ab, sa[bi]);
          check($sformatf("%s rd_we k=%0d", tag, k), dma_we, 0);
        end
        PH_WR: begin
          check($sformatf("%s wr_ab k=%0d", tag, k), dma_ab, da[bi]);
          check($sformatf("%s wr_do k=%0d", tag, k), dma_do, dd[bi]);
          check($sformatf("%s wr_we k=%0d", tag, k), dma_we, 1);
          bi++;
        end
        default: check($sformatf("%s idle_we k=%0d", tag, k), dma_we, 0);
      endcase
      exp_free = (sched[k] == PH_YIELD) || (sched[k] == PH_DONE);
      check($sformatf("%s rdy k=%0d", tag, k), cpu_rdy, exp_free);
      check($sformatf("%s own k=%0d", tag, k), bus_own, !exp_free);
      if (!cpu_rdy) low++;
      if (k == v.inj_k) begin
        cs = 1'b1; we = 1'b1; addr = v.inj_a; din = v.inj_d;
      end
      @(posedge clk); #1;
      cs = 1'b0; we = 1'b0;
    end

    check({tag, " rdy_low_cycles"}, low, v.exp_low);
    check({tag, " irq"}, irq, v.exp_irq);
    cpu_read(3'd0, lo); cpu_read(3'd1, hi);
    check({tag, " src_reg"}, {hi, lo}, v.exp_src);
    cpu_read(3'd2, lo); cpu_read(3'd3, hi);
    check({tag, " dst_reg"}, {hi, lo}, v.exp_dst);
    cpu_read(3'd4, lo); cpu_read(3'd5, hi);
    check({tag, " len_reg"}, {hi, lo}, 0);
    cpu_read(3'd7, lo);
    check({tag, " status"}, lo, 8'h02);
    check({tag, " rdy_after"}, cpu_rdy, 1);
    if (v.len != 0) begin
      check({tag, " last_byte"}, cur_mem(da[da.size()-1]), dd[dd.size()-1]);
    end
  endtask

  vec_t tbl [8];

  initial begin
    vec_t       rv;
    logic [7:0] r;
    int         n;

    tbl[0] = '{16'h0100, 16'h0200, 16'd4,  8'h01, -1, 3'd0, 8'h00, 16'h0104, 16'h0204, 9,  1'b0};
    tbl[1] = '{16'h1000, 16'h2000, 16'd40, 8'h01, -1, 3'd0, 8'h00, 16'h1028, 16'h2028, 83, 1'b0};
    tbl[2] = '{16'hF800, 16'h0300, 16'd3,  8'h09, -1, 3'd0, 8'h00, 16'hF803, 16'h0300, 7,  1'b0};
    tbl[3] = '{16'hFFFF, 16'h0500, 16'd2,  8'h01, -1, 3'd0, 8'h00, 16'h0001, 16'h0502, 5,  1'b0};
    tbl[4] = '{16'h3000, 16'h3100, 16'd16, 8'h03, -1, 3'd0, 8'h00, 16'h3010, 16'h3110, 33, 1'b1};
    tbl[5] = '{16'h3200, 16'h3300, 16'd17, 8'h05, -1, 3'd0, 8'h00, 16'h3200, 16'h3311, 36, 1'b0};
    // Writes landing in the single yield cycle of a 20-byte copy.
    tbl[6] = '{16'h4000, 16'h4100, 16'd20, 8'h01, 33, 3'd6, 8'h03, 16'h4014, 16'h4114, 42, 1'b1};
    tbl[7] = '{16'h4200, 16'h4300, 16'd20, 8'h01, 33, 3'd0, 8'hAA, 16'h4214, 16'h4314, 42, 1'b0};

    rst = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst cpu_rdy", cpu_rdy, 1);
    check("rst bus_own", bus_own, 0);
    check("rst dma_we", dma_we, 0);
    check("rst dma_ab", dma_ab, 0);
    check("rst dma_do", dma_do, 0);
    check("rst dout", dout, 0);
    check("rst irq", irq, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      cpu_read(3'(a), r);
      check($sformatf("rst reg%0d", a), r, 0);
    end

    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i], $sformatf("vec%0d", i));
    end

    // Third byte of the dst_fixed run must be the one left at 0x0300.
    check("dst_fixed final", cur_mem(16'h0300), pat(16'hF802));

    for (int i = 0; i < 12; i++) begin
      rv.src     = 16'h1000 + 16'($urandom_range(0, 16'h07FF));
      rv.dst     = 16'h5000 + 16'($urandom_range(0, 16'h07FF));
      rv.len     = 16'($urandom_range(1, 50));
      rv.ctrl    = 8'h01 | 8'($urandom_range(0, 7) << 1);
      rv.inj_k   = -1;
      rv.inj_a   = '0;
      rv.inj_d   = '0;
      rv.exp_src = rv.ctrl[2] ? rv.src : rv.src + rv.len;
      rv.exp_dst = rv.ctrl[3] ? rv.dst : rv.dst + rv.len;
      n          = int'(rv.len);
      rv.exp_low = 2 * n + (n + TB_BURST - 1) / TB_BURST;
      rv.exp_irq = rv.ctrl[1];
      run_xfer(rv, $sformatf("rand%0d", i));
    end

    // Zero-length start: never takes the bus, done the next cycle.
    cpu_write(3'd4, 8'h00);
    cpu_write(3'd5, 8'h00);
    cpu_write(3'd6, 8'h03);
    check("len0 bus_own", bus_own, 0);
    check("len0 cpu_rdy", cpu_rdy, 1);
    check("len0 irq", irq, 1);
    cpu_read(3'd7, r);
    check("len0 status", r, 8'h02);
    check("len0 bus_own2", bus_own, 0);

    // Reset during the second byte's write cycle.
    cpu_write(3'd0, 8'h00); cpu_write(3'd1, 8'h01);
    cpu_write(3'd2, 8'h00); cpu_write(3'd3, 8'h70);
    cpu_write(3'd4, 8'h04); cpu_write(3'd5, 8'h00);
    cpu_write(3'd6, 8'h03);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("abort in_wr2 we", dma_we, 1);
    check("abort in_wr2 ab", dma_ab, 16'h7001);
    rst = 1'b0;
    #1;
    check("abort cpu_rdy", cpu_rdy, 1);
    check("abort bus_own", bus_own, 0);
    check("abort dma_we", dma_we, 0);
    check("abort irq", irq, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort byte1 kept", cur_mem(16'h7000), pat(16'h0100));
    check("abort byte2 unwritten", written[16'h7001], 0);
    for (int a = 0; a < 8; a++) begin
      cpu_read(3'(a), r);
      check($sformatf("abort reg%0d", a), r, 0);
    end

    // Normal run with irq, then clear done through STATUS.
    rv = '{16'h6000, 16'h6100, 16'd2, 8'h03, -1, 3'd0, 8'h00, 16'h6002, 16'h6102, 5, 1'b1};
    run_xfer(rv, "clr_run");
    cpu_write(3'd7, 8'h02);
    check("clr irq", irq, 0);
    cpu_read(3'd7, r);
    check("clr status", r, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Memory-to-memory DMA engine and bus arbiter for the 6502 system bus.
- CPU programs source, destination and length through an 8-byte register window at F700-F7FF.
- On start, the block takes the address/data bus by holding CPU RDY low, then copies bytes through the shared RAM/video/IO decode.
- It releases the bus periodically for CPU fairness and raises an optional IRQ when done. The top level muxes dma_ab/dma_do/dma_we onto the bus while bus_own=1.

Parameters:
- BURST, 16, max bytes moved per bus grant before one mandatory CPU cycle; 0 means no release until done.
- LEN_W, 16, width of length counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- cs  input  1  register window select (CPU_AB[15:8]==F7)
- we  input  1  CPU write enable
- addr  input  3  register index (CPU_AB[2:0])
- din  input  8  CPU write data
- dout  output  8  register read data, registered
- mem_di  input  8  system read data bus, valid one cycle after address
- dma_ab  output  16  DMA address onto system bus
- dma_do  output  8  DMA write data
- dma_we  output  1  DMA write strobe
- bus_own  output  1  top selects DMA bus signals when 1
- cpu_rdy  output  1  to CPU RDY; low while DMA owns bus
- irq  output  1  level interrupt, done & irq_en

Behaviour:
- Registers:
  - 0/1 SRC lo/hi; 2/3 DST lo/hi; 4/5 LEN lo/hi.
  - 6 CTRL: b0 start (self-clearing), b1 irq_en, b2 src_fixed, b3 dst_fixed.
  - 7 STATUS: b0 busy, b1 done. Writing 1 to b1 clears done.
  - Reads return current live counters; dout updates on the clock edge after a cs&!we cycle.
- Reset values: all registers 0, dout=0, dma_ab=0, dma_do=0, dma_we=0, bus_own=0, cpu_rdy=1, irq=0, state IDLE.
- FSM states: IDLE, GRANT, RD, WR, YIELD, DONE.
  - IDLE: CTRL write with b0=1 and busy=0 sets busy, clears done, and goes to GRANT next cycle. If LEN=0 it goes straight to DONE.
  - GRANT: cpu_rdy=0 and bus_own=1 from this cycle on. It is a single hand-off cycle so that the CPU write that started the DMA completes first.
  - RD: dma_ab=SRC, dma_we=0.
  - WR: dma_ab=DST, dma_do=mem_di, dma_we=1. On exit, SRC+=1 unless src_fixed, DST+=1 unless dst_fixed (16-bit wrap FFFF->0000), LEN-=1, burst_cnt+=1.
  - After WR: if LEN==0 go to DONE; else if BURST!=0 and burst_cnt==BURST go to YIELD; else go to RD.
  - Each byte takes exactly 2 cycles.
  - YIELD: bus_own=0, cpu_rdy=1 for exactly one cycle, burst_cnt cleared, then GRANT.
  - DONE: bus_own=0, cpu_rdy=1, busy=0, done=1, then IDLE.
- CPU writes to the register window while busy (only possible in YIELD) are ignored except STATUS done-clear and CTRL irq_en. A start while busy is ignored.
- cpu_rdy and bus_own are registered outputs, complementary at all times.
- Asynchronous reset mid-transfer aborts immediately: bus returned, registers zeroed, no partial write is completed.
- dma_we is never asserted outside WR.

Test Plan:
- SRC=0x0100, DST=0x0200, LEN=4, BURST=16, start -> GRANT then 8 cycles RD/WR, 4 bytes copied, cpu_rdy low for 9 cycles, done=1, LEN reads 0, SRC reads 0x0104.
- LEN=0 start -> no bus_own assertion, done=1 next cycle, irq=1 if irq_en.
- LEN=40, BURST=16 -> cpu_rdy pulses high exactly one cycle after bytes 16 and 32; data intact.
- dst_fixed=1, SRC=0xF800, DST=0x0300, LEN=3 -> three writes to 0x0300, final value = ROM[0xF802].
- SRC=0xFFFF, LEN=2 -> second read at 0x0000.
- rst low during WR of byte 2 -> next cycle cpu_rdy=1, bus_own=0, dma_we=0, all registers 0; STATUS write 0x02 after a normal run clears done and irq.
